div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle iterative restoring divider for the sail-core execute stage.
- Implements the RV32M DIV/DIVU/REM/REMU operations.
- Sits beside the DSP add/sub datapath: takes operands from the ALU operand muxes and returns a 32-bit result to the ALU result mux.
- Signals busy so the pipeline can stall.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- dividend  input  WIDTH  rs1 value; sampled with start.
- divisor  input  WIDTH  rs2 value; sampled with start.
- busy  output  1  high from the edge that accepts start until done falls.
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- result  output  WIDTH  quotient or remainder; held until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, internal registers cleared. rst wins over every other input.
- States and transitions:
  - IDLE -> CALC on start: latch op, |dividend|, |divisor|, and the signs. Absolute values apply only for DIV/REM. Set cnt=0 and clear the 33-bit partial remainder.
  - CALC: one iteration per clock.
    - r' = {r[31:0], q[31]}; q shifted left.
    - If r' >= {0,|divisor|} (33-bit unsigned compare): r = r' - divisor and q[0]=1; otherwise r = r' and q[0]=0.
    - Leaves after 32 iterations, i.e. when cnt==31.
  - FIX: apply the sign and select the result into the result register; -> DONE.
  - DONE: done=1 for exactly one cycle; -> IDLE.
- Latency:
  - Start sampled at edge E0; CALC runs E1..E32; FIX at E33; done high during the cycle after E33.
  - busy falls together with done at E34.
  - A start in the same cycle as done is ignored; start is accepted only while busy==0.
- Signs:
  - Quotient negated iff the operand signs differ and divisor != 0.
  - Remainder negated iff the dividend is negative.
  - All arithmetic is two's complement modulo 2^32.
- Divide by zero: quotient=0xFFFFFFFF for both DIV and DIVU; remainder=dividend.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. These fall out of the algorithm and need no special case.
- Changes to operand inputs while busy have no effect.
- Reset mid-operation aborts immediately, with no done pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE on start, if divisor==0 or |dividend| < |divisor| (unsigned, after abs), go IDLE->FIX directly.
  - Preload q=0xFFFFFFFF/r=|dividend| (divisor zero) or q=0/r=|dividend| (small dividend).
  - done is then high in the cycle after E1.
- Undefined: every operation takes the full 32 iterations. Results are bit-identical either way.

Decomposition:
- Shared package/header div_pkg holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - state encodings S_IDLE/S_CALC/S_FIX/S_DONE.
  - the WIDTH constant.
- One sub-module, div_step: combinational single restoring iteration, taking (r, q, divisor) and returning (r_next, q_next). It is instantiated once in div_iter.

Test Plan:
- DIVU 100 / 7 -> result 14. done exactly 33 clocks after the start edge; busy high for 34 cycles.
- REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF (-1). DIV with the same operands -> 0xFFFFFFFD (-3).
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DIV 0xFFFFFFF6 / 0 -> 0xFFFFFFFF. REMU 0xFFFFFFF6 / 0 -> 0xFFFFFFF6. With DIV_EARLY_OUT_EN, done arrives in the cycle after E1.
- Assert rst at iteration 10 of DIVU 1000/3 -> busy=0, done=0, result=0 next cycle. A new DIVU 9/3 then returns 3 with normal latency.
- Hold start high continuously over three back-to-back ops: each is accepted only when busy==0, and no start is accepted while done==1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and encodings for the iterative divider (op codes, FSM states, width).
package div_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {r,q} left, subtract divisor if it fits.
// Zero latency; no flow control.
module div_step
  import div_pkg::*;
#(
  parameter int STEP_W = WIDTH
) (
  input  logic [STEP_W:0]   r,
  input  logic [STEP_W-1:0] q,
  input  logic [STEP_W-1:0] divisor,
  output logic [STEP_W:0]   r_next,
  output logic [STEP_W-1:0] q_next
);
  logic [STEP_W:0] r_sh;
  logic [STEP_W:0] diff;
  logic            ge;

  always_comb begin
    r_sh   = {r[STEP_W-1:0], q[STEP_W-1]};
    diff   = r_sh - {1'b0, divisor};
    ge     = (r_sh >= {1'b0, divisor});
    r_next = ge ? diff : r_sh;
    q_next = {q[STEP_W-2:0], ge};
  end
endmodule

// File: rtl/div_iter.sv
// RV32M DIV/DIVU/REM/REMU iterative divider: 34 busy cycles, done 33 clocks after start; start ignored while busy.
// DIV_EARLY_OUT_EN skips the iterations for divide-by-zero and |dividend| < |divisor|.
module div_iter
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_rem_q, op_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_signed;
  logic             neg_dvd, neg_dvs;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  div_step #(.STEP_W(WIDTH)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (dvs_q),
    .r_next  (step_r),
    .q_next  (step_q)
  );

  always_comb begin
    is_signed = ~op[0];
    neg_dvd   = is_signed & dividend[WIDTH-1];
    neg_dvs   = is_signed & divisor[WIDTH-1];
    abs_dvd   = neg_dvd ? -dividend : dividend;
    abs_dvs   = neg_dvs ? -divisor : divisor;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_rem_d  = op[1];
          neg_quo_d = (neg_dvd ^ neg_dvs) & (divisor != '0);
          neg_rem_d = neg_dvd;
          dvs_d     = abs_dvs;
          cnt_d     = '0;
          r_d       = '0;
          q_d       = abs_dvd;
          state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          // Preload the values the full iteration would converge to.
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, abs_dvd};
            state_d = S_FIX;
          end else if (abs_dvd < abs_dvs) begin
            q_d     = '0;
            r_d     = {1'b0, abs_dvd};
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_rem_q) result_d = neg_rem_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        else          result_d = neg_quo_q ? -q_q : q_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter against an arithmetic RV32M division model.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] aa, bb;
    aa = (!o[0] && a[31]) ? -a : a;
    bb = (!o[0] && b[31]) ? -b : b;
    if (b == 0 || aa < bb) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return 32'h0;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat = 0;
    int bcnt = 1;
    wait_idle();
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_on_accept"}, {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) bcnt++;
      dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    end
    check({tag, " latency"}, lat, exp_lat(o, a, b));
    check({tag, " busy_cycles"}, bcnt, exp_lat(o, a, b) + 1);
    check({tag, " result"}, result, ref_res(o, a, b));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, " busy_fall"}, {31'b0, busy}, 32'd0);
    check({tag, " result_hold"}, result, ref_res(o, a, b));
  endtask

  initial begin
    logic [1:0]  cur_op;
    logic [31:0] cur_a, cur_b;
    int n;

    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0", 2'b00, 32'hFFFF_FFF6, 32'h0);
    run_op("remu_by0", 2'b11, 32'hFFFF_FFF6, 32'h0);
    run_op("rem_by0", 2'b10, 32'hFFFF_FFF6, 32'h0);
    run_op("divu_by0", 2'b01, 32'h1234_5678, 32'h0);

    // Abort in the middle of an operation.
    wait_idle();
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", result, 32'd0);
    rst = 1'b0;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3);

    // start held high across back-to-back operations.
    cur_op = 2'($urandom); cur_a = pick(); cur_b = pick();
    op = cur_op; dividend = cur_a; divisor = cur_b;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (busy !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("b2b%0d accept_delay", i), n, 1);
      begin
        logic [1:0]  o;
        logic [31:0] a, b;
        o = cur_op; a = cur_a; b = cur_b;
        cur_op = 2'($urandom); cur_a = pick(); cur_b = pick();
        op = cur_op; dividend = cur_a; divisor = cur_b;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        check($sformatf("b2b%0d latency", i), n, exp_lat(o, a, b));
        check($sformatf("b2b%0d result", i), result, ref_res(o, a, b));
        @(posedge clk); #1;
        check($sformatf("b2b%0d no_accept_on_done", i), {31'b0, busy}, 32'd0);
      end
    end
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom); a = pick(); b = pick();
      run_op($sformatf("rnd%0d op%0d %08h/%08h", i, o, a, b), o, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
